mem_copy_engine: RTL and testbench

- Initiator-side sequencer for the single-port synchronous-read scratch memory (16 x 8, registered read address, write-enable port).
- Drives the memory's adr/dat_w/we and consumes its dat_r to perform block copy and block fill operations on command.
- Reports busy/done and a modular checksum of all data written.
- Sits between the control register block and the scratch memory.

---
 rtl/mem_copy_engine_if.sv | 13 +
 rtl/mem_copy_engine.sv | 118 +++++++++++
 tb/tb_mem_copy_engine.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_engine_if.sv
// Scratch-memory port between the copy engine (master) and the 16x8 synchronous-read memory (slave).
interface mem_copy_engine_if #(
   parameter int AW = 4,
   parameter int DW = 8
) ();
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_dat_w;
   logic          mem_we;
   logic [DW-1:0] mem_dat_r;

   modport master (output mem_adr, output mem_dat_w, output mem_we, input mem_dat_r);
   modport slave  (input mem_adr, input mem_dat_w, input mem_we, output mem_dat_r);
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / block fill sequencer for the single-port scratch memory, with a running write checksum.
//
// state | meaning
// IDLE  | waiting for start, memory port quiet
// RD    | copy: present source address, word arrives next cycle
// WR    | copy: write the word read in RD to the destination
// FILL  | fill: write fill pattern to destination, one word per cycle
// FIN   | one-cycle done pulse, then back to IDLE
module mem_copy_engine #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          op,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW:0]   len,
   input  logic [DW-1:0] fill_val,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] sum,
   mem_copy_engine_if.master mem
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_FIN} state_t;

   state_t        state, state_nxt;
   logic          op_q;
   logic [AW-1:0] src_q, dst_q;
   logic [AW:0]   len_q, idx, idx_inc;
   logic [DW-1:0] fill_q, sum_q;
   logic          last_word;

   assign idx_inc   = idx + {{AW{1'b0}}, 1'b1};
   assign last_word = (idx_inc == len_q);
   assign sum       = sum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) begin
            if (len == '0) state_nxt = S_FIN;
            else if (op)   state_nxt = S_FILL;
            else           state_nxt = S_RD;
         end
         S_RD:   state_nxt = S_WR;
         S_WR:   state_nxt = last_word ? S_FIN : S_RD;
         S_FILL: state_nxt = last_word ? S_FIN : S_FILL;
         S_FIN:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Address, write data and enable are decoded straight from state so a reset kills mem_we at once.
   always_comb begin
      mem.mem_adr   = '0;
      mem.mem_dat_w = '0;
      mem.mem_we    = 1'b0;
      case (state)
         S_RD: mem.mem_adr = src_q + idx[AW-1:0];
         S_WR: begin
            mem.mem_adr   = dst_q + idx[AW-1:0];
            mem.mem_dat_w = mem.mem_dat_r;
            mem.mem_we    = 1'b1;
         end
         S_FILL: begin
            mem.mem_adr   = dst_q + idx[AW-1:0];
            mem.mem_dat_w = fill_q;
            mem.mem_we    = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy = (state == S_RD) || (state == S_WR) || (state == S_FILL);
   assign done = (state == S_FIN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q   <= 1'b0;
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         fill_q <= '0;
         idx    <= '0;
         sum_q  <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               op_q   <= op;
               src_q  <= src;
               dst_q  <= dst;
               len_q  <= len;
               fill_q <= fill_val;
               idx    <= '0;
               sum_q  <= '0;
            end
            S_WR: begin
               sum_q <= sum_q + mem.mem_dat_r;
               idx   <= idx_inc;
            end
            S_FILL: begin
               sum_q <= sum_q + fill_q;
               idx   <= idx_inc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: behavioural scratch memory, reference memory model and a write scoreboard.
module tb_mem_copy_engine;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          op = 1'b0;
   logic [AW-1:0] src = '0;
   logic [AW-1:0] dst = '0;
   logic [AW:0]   len = '0;
   logic [DW-1:0] fill_val = '0;
   logic          busy, done;
   logic [DW-1:0] sum;

   mem_copy_engine_if #(.AW(AW), .DW(DW)) bus ();

   mem_copy_engine #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst),
      .len(len), .fill_val(fill_val), .busy(busy), .done(done), .sum(sum), .mem(bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_adr] <= bus.mem_dat_w;
      bus.mem_dat_r <= mem[bus.mem_adr];
   end

   typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
   wr_t exp_q[$];
   wr_t e;
   int total = 0;
   int bad = 0;
   int wr_cnt = 0;

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write adr=%0h dat=%0h", bus.mem_adr, bus.mem_dat_w);
         end else begin
            e = exp_q.pop_front();
            if (bus.mem_adr !== e.a || bus.mem_dat_w !== e.d) begin
               bad++;
               $display("FAIL write adr/dat actual=%0h/%0h required=%0h/%0h",
                        bus.mem_adr, bus.mem_dat_w, e.a, e.d);
            end
         end
      end
   end

   task automatic preload();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      mem[0] = 8'h90; mem[1] = 8'hB3; mem[2] = 8'h23; mem[3] = 8'hFE;
      mem[8] = 8'h57; mem[9] = 8'h93; mem[10] = 8'h5A; mem[11] = 8'h77;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (mem[i] !== ref_mem[i]) begin
            bad++;
            $display("FAIL %s mem[%0d] actual=%0h required=%0h", tag, i, mem[i], ref_mem[i]);
         end
      end
   endtask

   // Issues one command, optionally pulses a stray start in loop cycle 'mid', returns edges-to-done.
   task automatic run_cmd(input logic o, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW:0] n, input logic [DW-1:0] fv, input int mid,
                          output int lat);
      logic [DW-1:0] esum;
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      esum = '0;
      for (int k = 0; k < int'(n); k++) begin
         a = d + AW'(k);
         w = o ? fv : ref_mem[s + AW'(k)];
         ref_mem[a] = w;
         exp_q.push_back('{a, w});
         esum += w;
      end
      wr_cnt = 0;
      @(negedge clk);
      op = o; src = s; dst = d; len = n; fill_val = fv; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = ~o; src = ~s; dst = ~d; len = '1; fill_val = ~fv;
      lat = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (c == 0 && n != 0) begin
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("FAIL busy_first_cycle actual=%b required=1", busy);
            end
         end
         if (done === 1'b1) begin
            lat = c;
            break;
         end
         if (c == mid) begin
            start = 1'b1; op = ~o; src = s + 4'd3; dst = d + 4'd5; len = 5'd2; fill_val = 8'h11;
         end
         @(posedge clk);
         #1 start = 1'b0;
      end
      total++;
      if (lat < 0) begin
         bad++;
         $display("FAIL done_timeout actual=none required=done");
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL done_pulse done/busy actual=%b/%b required=0/0", done, busy);
      end
      total++;
      if (sum !== esum) begin
         bad++;
         $display("FAIL sum actual=%0h required=%0h", sum, esum);
      end
      total++;
      if (wr_cnt != int'(n) || exp_q.size() != 0) begin
         bad++;
         $display("FAIL write_count actual=%0d pending=%0d required=%0d", wr_cnt, exp_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || bus.mem_we !== 1'b0 ||
          bus.mem_adr !== 4'h0 || bus.mem_dat_w !== 8'h00) begin
         bad++;
         $display("FAIL reset_state busy=%b done=%b sum=%0h we=%b adr=%0h dat_w=%0h required all zero",
                  busy, done, sum, bus.mem_we, bus.mem_adr, bus.mem_dat_w);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_copy();
      int lat;
      logic [DW-1:0] want [4];
      want[0] = 8'h90; want[1] = 8'hB3; want[2] = 8'h23; want[3] = 8'hFE;
      preload();
      run_cmd(1'b0, 4'd0, 4'd8, 5'd4, 8'h00, -1, lat);
      total++;
      if (lat != 8) begin bad++; $display("FAIL copy_latency actual=%0d required=8", lat); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem[8+i] !== want[i]) begin
            bad++;
            $display("FAIL copy_data mem[%0d] actual=%0h required=%0h", 8 + i, mem[8+i], want[i]);
         end
      end
      total++;
      if (sum !== 8'h64) begin bad++; $display("FAIL copy_sum actual=%0h required=64", sum); end
      check_mem("copy");
   endtask

   task automatic test_fill_wrap();
      int lat;
      run_cmd(1'b1, 4'd0, 4'd14, 5'd4, 8'h5A, -1, lat);
      total++;
      if (lat != 4) begin bad++; $display("FAIL fill_latency actual=%0d required=4", lat); end
      total++;
      if (mem[14] !== 8'h5A || mem[15] !== 8'h5A || mem[0] !== 8'h5A || mem[1] !== 8'h5A ||
          mem[2] !== 8'h23) begin
         bad++;
         $display("FAIL fill_wrap m14=%0h m15=%0h m0=%0h m1=%0h m2=%0h required 5a,5a,5a,5a,23",
                  mem[14], mem[15], mem[0], mem[1], mem[2]);
      end
      total++;
      if (sum !== 8'h68) begin bad++; $display("FAIL fill_sum actual=%0h required=68", sum); end
      check_mem("fill");
   endtask

   task automatic test_overlap();
      int lat;
      preload();
      run_cmd(1'b0, 4'd0, 4'd1, 5'd3, 8'h00, -1, lat);
      total++;
      if (lat != 6) begin bad++; $display("FAIL overlap_latency actual=%0d required=6", lat); end
      total++;
      if (mem[0] !== 8'h90 || mem[1] !== 8'h90 || mem[2] !== 8'h90 || mem[3] !== 8'h90) begin
         bad++;
         $display("FAIL overlap_data %0h %0h %0h %0h required 90,90,90,90",
                  mem[0], mem[1], mem[2], mem[3]);
      end
      total++;
      if (sum !== 8'hB0) begin bad++; $display("FAIL overlap_sum actual=%0h required=b0", sum); end
   endtask

   task automatic test_len0_and_ignored_start();
      int lat;
      run_cmd(1'b0, 4'd3, 4'd5, 5'd0, 8'h00, -1, lat);
      total++;
      if (lat < 0 || lat > 1) begin bad++; $display("FAIL len0_latency actual=%0d required<=1", lat); end
      total++;
      if (sum !== 8'h00) begin bad++; $display("FAIL len0_sum actual=%0h required=0", sum); end
      run_cmd(1'b1, 4'd0, 4'd4, 5'd4, 8'hC3, 1, lat);
      total++;
      if (lat != 4) begin bad++; $display("FAIL ignored_start_latency actual=%0d required=4", lat); end
      check_mem("ignored_start");
   endtask

   task automatic test_reset_mid_op();
      int lat;
      logic [AW-1:0] a;
      preload();
      wr_cnt = 0;
      for (int k = 0; k < 2; k++) begin
         a = 4'd8 + AW'(k);
         ref_mem[a] = ref_mem[k];
         exp_q.push_back('{a, ref_mem[k]});
      end
      @(negedge clk);
      op = 1'b0; src = 4'd0; dst = 4'd8; len = 5'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL word2_write_active actual=%b required=1", bus.mem_we); end
      rst = 1'b0;
      #1;
      total++;
      if (bus.mem_we !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_abort we=%b busy=%b sum=%0h done=%b required 0,0,0,0",
                  bus.mem_we, busy, sum, done);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      total++;
      if (wr_cnt != 2 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL reset_writes actual=%0d pending=%0d required=2", wr_cnt, exp_q.size());
      end
      check_mem("reset_abort");
      run_cmd(1'b0, 4'd8, 4'd12, 5'd4, 8'h00, -1, lat);
      total++;
      if (lat != 8) begin bad++; $display("FAIL post_reset_latency actual=%0d required=8", lat); end
      check_mem("post_reset");
   endtask

   task automatic test_back_to_back();
      int lat;
      run_cmd(1'b1, 4'd0, 4'd3, 5'd16, 8'h3C, -1, lat);
      total++;
      if (lat != 16) begin bad++; $display("FAIL full_fill_latency actual=%0d required=16", lat); end
      mem[7] = 8'hA5; ref_mem[7] = 8'hA5;
      run_cmd(1'b0, 4'd5, 4'd5, 5'd16, 8'h00, -1, lat);
      total++;
      if (lat != 32) begin bad++; $display("FAIL full_copy_latency actual=%0d required=32", lat); end
      check_mem("back_to_back");
   endtask

   initial begin
      preload();
      test_reset();
      test_copy();
      test_fill_wrap();
      test_overlap();
      test_len0_and_ignored_start();
      test_reset_mid_op();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end
endmodule
